digilock_controller_n: RTL and testbench

- Parametrised successor of the DigiLock control unit.
- Owns the password store internally.
- Accepts N-digit entry in two modes:
  - Configure: new password entered twice, committed only if both entries match.
  - Verify: entry compared against the stored password.
- Adds failed-attempt lockout, inter-key timeout, timed unlock and cancel.
- Sits between the keypad decoder (key strobe plus digit) and the lock actuator/LED outputs.

---
 rtl/digilock_controller_n.sv | 211 +++++++++++++++++++++
 tb/tb_digilock_controller_n.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digilock_controller_n.sv
`default_nettype none
//============================================================================
// Module   : digilock_controller_n
// Desc     : N-digit keypad lock controller with configure/verify modes,
//            failed-attempt lockout, inter-key timeout and timed unlock.
// Revision : 1.0 - initial release
//============================================================================
module digilock_controller_n #(
    parameter int                          N_DIGITS       = 4,
    parameter int                          DIGIT_W        = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_PWD    = '0,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          LOCKOUT_CYCLES = 1000,
    parameter int                          OPEN_CYCLES    = 500,
    parameter int                          TIMEOUT_CYCLES = 5000
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             modo,
    input  logic                             tecla_ativada,
    input  logic [DIGIT_W-1:0]               tecla,
    input  logic                             cancela,
    output logic                             aberto,
    output logic                             erro,
    output logic                             config_ok,
    output logic                             bloqueado,
    output logic [$clog2(N_DIGITS+1)-1:0]    digitos,
    output logic                             ocupado
);

    localparam int c_pw = N_DIGITS * DIGIT_W;
    localparam int c_dw = $clog2(N_DIGITS + 1);
    localparam int c_fw = $clog2(MAX_TRIES + 1);
    localparam int c_cw = $clog2(((LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES) + 1);
    localparam int c_tw = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [c_dw-1:0] c_last      = c_dw'(N_DIGITS - 1);
    localparam logic [c_fw-1:0] c_max_tries = c_fw'(MAX_TRIES);
    localparam logic [c_cw-1:0] c_open_end  = c_cw'(OPEN_CYCLES - 1);
    localparam logic [c_cw-1:0] c_lock_end  = c_cw'(LOCKOUT_CYCLES - 1);
    localparam logic [c_tw-1:0] c_to_end    = c_tw'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET_A   = 3'd1,
        S_SET_B   = 3'd2,
        S_VERIFY  = 3'd3,
        S_OPEN    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t            r_state, w_state_nx, w_phase;
    logic [c_pw-1:0]   r_stored, w_stored_nx;
    logic [c_pw-1:0]   r_shadow, w_shadow_nx;
    logic              r_mismatch, w_mismatch_nx, w_mis;
    logic [c_fw-1:0]   r_fails, w_fails_nx, w_fails_inc;
    logic [c_cw-1:0]   r_cnt, w_cnt_nx;
    logic [c_tw-1:0]   r_idle, w_idle_nx;
    logic [c_dw-1:0]   r_dig, w_dig_nx, w_idx;
    logic              w_erro_nx, w_cfg_nx, w_abort;

    assign digitos = r_dig;

    always_comb begin
        w_state_nx    = r_state;
        w_stored_nx   = r_stored;
        w_shadow_nx   = r_shadow;
        w_mismatch_nx = r_mismatch;
        w_fails_nx    = r_fails;
        w_cnt_nx      = r_cnt;
        w_idle_nx     = r_idle;
        w_dig_nx      = r_dig;
        w_erro_nx     = 1'b0;
        w_cfg_nx      = 1'b0;
        w_abort       = 1'b0;
        w_phase       = r_state;
        w_idx         = r_dig;
        w_mis         = r_mismatch;
        w_fails_inc   = r_fails + 1'b1;

        case (r_state)
            S_OPEN: begin
                if (cancela || (r_cnt == c_open_end)) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (r_cnt == c_lock_end) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                if ((r_state != S_IDLE) && cancela) begin
                    w_abort = 1'b1;
                end else if (tecla_ativada) begin
                    // The first key from IDLE is processed as digit 0 of the chosen phase
                    if (r_state == S_IDLE) begin
                        w_phase = modo ? S_SET_A : S_VERIFY;
                        w_idx   = '0;
                        w_mis   = 1'b0;
                    end
                    w_idle_nx  = '0;
                    w_state_nx = w_phase;
                    w_dig_nx   = w_idx + 1'b1;
                    case (w_phase)
                        S_SET_A: begin
                            w_shadow_nx[w_idx*DIGIT_W +: DIGIT_W] = tecla;
                            if (w_idx == c_last) begin
                                w_state_nx = S_SET_B;
                                w_dig_nx   = '0;
                            end
                        end
                        S_SET_B: begin
                            w_mis         = w_mis | (tecla != r_shadow[w_idx*DIGIT_W +: DIGIT_W]);
                            w_mismatch_nx = w_mis;
                            if (w_idx == c_last) begin
                                w_state_nx    = S_IDLE;
                                w_dig_nx      = '0;
                                w_mismatch_nx = 1'b0;
                                w_shadow_nx   = '0;
                                if (!w_mis) begin
                                    w_stored_nx = r_shadow;
                                    w_cfg_nx    = 1'b1;
                                end else begin
                                    w_erro_nx = 1'b1;
                                end
                            end
                        end
                        default: begin
                            w_mis         = w_mis | (tecla != r_stored[w_idx*DIGIT_W +: DIGIT_W]);
                            w_mismatch_nx = w_mis;
                            if (w_idx == c_last) begin
                                w_dig_nx      = '0;
                                w_mismatch_nx = 1'b0;
                                w_cnt_nx      = '0;
                                if (!w_mis) begin
                                    w_fails_nx = '0;
                                    w_state_nx = S_OPEN;
                                end else begin
                                    w_erro_nx = 1'b1;
                                    if (w_fails_inc == c_max_tries) begin
                                        w_fails_nx = '0;
                                        w_state_nx = S_LOCKOUT;
                                    end else begin
                                        w_fails_nx = w_fails_inc;
                                        w_state_nx = S_IDLE;
                                    end
                                end
                            end
                        end
                    endcase
                end else if ((r_state != S_IDLE) && (TIMEOUT_CYCLES > 0)) begin
                    if (r_idle == c_to_end) begin
                        w_abort = 1'b1;
                    end else begin
                        w_idle_nx = r_idle + 1'b1;
                    end
                end
            end
        endcase

        // Cancel and timeout share one silent exit that leaves the failure count alone
        if (w_abort) begin
            w_state_nx    = S_IDLE;
            w_dig_nx      = '0;
            w_shadow_nx   = '0;
            w_mismatch_nx = 1'b0;
            w_idle_nx     = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_stored   <= DEFAULT_PWD;
            r_shadow   <= '0;
            r_mismatch <= 1'b0;
            r_fails    <= '0;
            r_cnt      <= '0;
            r_idle     <= '0;
            r_dig      <= '0;
            aberto     <= 1'b0;
            erro       <= 1'b0;
            config_ok  <= 1'b0;
            bloqueado  <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_stored   <= w_stored_nx;
            r_shadow   <= w_shadow_nx;
            r_mismatch <= w_mismatch_nx;
            r_fails    <= w_fails_nx;
            r_cnt      <= w_cnt_nx;
            r_idle     <= w_idle_nx;
            r_dig      <= w_dig_nx;
            aberto     <= (w_state_nx == S_OPEN);
            erro       <= w_erro_nx;
            config_ok  <= w_cfg_nx;
            bloqueado  <= (w_state_nx == S_LOCKOUT);
            ocupado    <= (w_state_nx != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digilock_controller_n.sv
`default_nettype none
//============================================================================
// Module   : tb_digilock_controller_n
// Desc     : Vector table, directed corner sequences and randomized run
//            against a queue-based reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_digilock_controller_n;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic       modo, key, cancela;
    logic [7:0] tecla;

    always #5 clk = ~clk;

    logic       a_aberto, a_erro, a_cfg, a_bloq, a_ocup;
    logic [2:0] a_dig;
    logic       b_aberto, b_erro, b_cfg, b_bloq, b_ocup;
    logic [1:0] b_dig;
    logic       c_aberto, c_erro, c_cfg, c_bloq, c_ocup;
    logic       c_dig;

    digilock_controller_n #(.N_DIGITS(4), .DIGIT_W(4), .DEFAULT_PWD(16'h0000), .MAX_TRIES(3),
        .LOCKOUT_CYCLES(16), .OPEN_CYCLES(500), .TIMEOUT_CYCLES(20)) u_dut_a (
        .clk(clk), .reset_n(rst_a), .modo(modo), .tecla_ativada(key), .tecla(tecla[3:0]),
        .cancela(cancela), .aberto(a_aberto), .erro(a_erro), .config_ok(a_cfg),
        .bloqueado(a_bloq), .digitos(a_dig), .ocupado(a_ocup));

    localparam int NB = 3, MAXB = 2, LOCKB = 9, OPENB = 7, TOB = 6;
    localparam logic [5:0] DEFB = 6'b10_01_11;

    digilock_controller_n #(.N_DIGITS(NB), .DIGIT_W(2), .DEFAULT_PWD(DEFB), .MAX_TRIES(MAXB),
        .LOCKOUT_CYCLES(LOCKB), .OPEN_CYCLES(OPENB), .TIMEOUT_CYCLES(TOB)) u_dut_b (
        .clk(clk), .reset_n(rst_b), .modo(modo), .tecla_ativada(key), .tecla(tecla[1:0]),
        .cancela(cancela), .aberto(b_aberto), .erro(b_erro), .config_ok(b_cfg),
        .bloqueado(b_bloq), .digitos(b_dig), .ocupado(b_ocup));

    digilock_controller_n #(.N_DIGITS(1), .DIGIT_W(8), .DEFAULT_PWD(8'hA5), .MAX_TRIES(3),
        .LOCKOUT_CYCLES(16), .OPEN_CYCLES(500), .TIMEOUT_CYCLES(20)) u_dut_c (
        .clk(clk), .reset_n(rst_c), .modo(modo), .tecla_ativada(key), .tecla(tecla),
        .cancela(cancela), .aberto(c_aberto), .erro(c_erro), .config_ok(c_cfg),
        .bloqueado(c_bloq), .digitos(c_dig), .ocupado(c_ocup));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic k, input logic [7:0] t, input logic c);
        modo = m; key = k; tecla = t; cancela = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset(input logic a, input logic b, input logic c);
        modo = 1'b0; key = 1'b0; tecla = 8'h00; cancela = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(posedge clk);
        #1;
        rst_a = a; rst_b = b; rst_c = c;
    endtask

    task automatic chk_a(input string tag, input logic ea, input logic ee, input logic ec,
                         input logic eb, input int ed, input logic eo);
        chk({tag, ".aberto"},    a_aberto, ea);
        chk({tag, ".erro"},      a_erro,   ee);
        chk({tag, ".config_ok"}, a_cfg,    ec);
        chk({tag, ".bloqueado"}, a_bloq,   eb);
        chk({tag, ".digitos"},   a_dig,    ed);
        chk({tag, ".ocupado"},   a_ocup,   eo);
    endtask

    task automatic verify4_a(input logic [3:0] d);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, {4'h0, d}, 1'b0);
    endtask

    // One cycle per record: inputs, then the outputs expected after the edge
    typedef struct {
        logic m, k, c;
        logic [3:0] t;
        logic ea, ee, ec, eb, eo;
        int   ed;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic m, input logic k, input logic [3:0] t, input logic c,
                                input logic ea, input logic ee, input logic ec, input logic eb,
                                input int ed, input logic eo);
        vec_t v;
        v.m = m; v.k = k; v.t = t; v.c = c;
        v.ea = ea; v.ee = ee; v.ec = ec; v.eb = eb; v.ed = ed; v.eo = eo;
        tbl.push_back(v);
    endfunction

    // Reference model for DUT B: digits held in queues, timers count down
    localparam int M_IDLE = 0, M_SETA = 1, M_SETB = 2, M_VER = 3, M_OPEN = 4, M_LOCK = 5;
    int m_st, m_fails, m_rem, m_idle;
    int m_stored[NB];
    int m_first[NB];
    int m_cur[$];
    bit m_erro, m_cfg;

    task automatic m_reset();
        m_st = M_IDLE; m_fails = 0; m_rem = 0; m_idle = 0;
        m_cur.delete();
        for (int i = 0; i < NB; i++) begin
            m_stored[i] = int'((DEFB >> (2 * i)) & 6'd3);
            m_first[i]  = 0;
        end
        m_erro = 0; m_cfg = 0;
    endtask

    task automatic m_finish();
        bit eq;
        eq = 1;
        if (m_st == M_SETA) begin
            for (int i = 0; i < NB; i++) m_first[i] = m_cur[i];
            m_st = M_SETB;
        end else if (m_st == M_SETB) begin
            for (int i = 0; i < NB; i++) if (m_cur[i] != m_first[i]) eq = 0;
            if (eq) begin
                for (int i = 0; i < NB; i++) m_stored[i] = m_first[i];
                m_cfg = 1;
            end else begin
                m_erro = 1;
            end
            m_st = M_IDLE;
        end else begin
            for (int i = 0; i < NB; i++) if (m_cur[i] != m_stored[i]) eq = 0;
            if (eq) begin
                m_fails = 0; m_st = M_OPEN; m_rem = OPENB;
            end else begin
                m_erro = 1;
                m_fails++;
                if (m_fails == MAXB) begin
                    m_fails = 0; m_st = M_LOCK; m_rem = LOCKB;
                end else begin
                    m_st = M_IDLE;
                end
            end
        end
        m_cur.delete();
    endtask

    task automatic m_step(input bit m, input bit k, input int t, input bit c);
        m_erro = 0; m_cfg = 0;
        if (m_st == M_OPEN) begin
            m_rem--;
            if (c || m_rem == 0) m_st = M_IDLE;
        end else if (m_st == M_LOCK) begin
            m_rem--;
            if (m_rem == 0) m_st = M_IDLE;
        end else if (m_st == M_IDLE) begin
            if (k) begin
                m_st = m ? M_SETA : M_VER;
                m_cur.delete();
                m_cur.push_back(t);
                m_idle = 0;
                if (m_cur.size() == NB) m_finish();
            end
        end else if (c) begin
            m_st = M_IDLE; m_cur.delete(); m_idle = 0;
        end else if (k) begin
            m_cur.push_back(t);
            m_idle = 0;
            if (m_cur.size() == NB) m_finish();
        end else begin
            m_idle++;
            if (m_idle == TOB) begin
                m_st = M_IDLE; m_cur.delete(); m_idle = 0;
            end
        end
    endtask

    initial begin
        int n;
        int kp, exp_d, t;
        bit m, k, c;

        // ---------------- vector table on DUT A ----------------
        do_reset(1'b0, 1'b0, 1'b0);
        chk_a("reset", 0, 0, 0, 0, 0, 0);
        rst_a = 1'b1;

        add(1,1,4'd1,0, 0,0,0,0,1,1);
        add(0,1,4'd2,0, 0,0,0,0,2,1);
        add(0,1,4'd3,0, 0,0,0,0,3,1);
        add(0,1,4'd4,0, 0,0,0,0,0,1);
        add(0,1,4'd1,0, 0,0,0,0,1,1);
        add(0,1,4'd2,0, 0,0,0,0,2,1);
        add(0,1,4'd3,0, 0,0,0,0,3,1);
        add(0,1,4'd4,0, 0,0,1,0,0,0);
        add(0,0,4'd0,0, 0,0,0,0,0,0);
        add(0,1,4'd1,0, 0,0,0,0,1,1);
        add(0,1,4'd2,0, 0,0,0,0,2,1);
        add(0,1,4'd3,0, 0,0,0,0,3,1);
        add(0,1,4'd4,0, 1,0,0,0,0,1);
        add(0,1,4'd5,0, 1,0,0,0,0,1);
        add(0,0,4'd0,1, 0,0,0,0,0,0);
        add(0,1,4'd0,0, 0,0,0,0,1,1);
        add(0,1,4'd0,0, 0,0,0,0,2,1);
        add(0,1,4'd0,0, 0,0,0,0,3,1);
        add(0,1,4'd0,0, 0,1,0,0,0,0);
        add(0,0,4'd0,0, 0,0,0,0,0,0);
        add(1,1,4'd5,0, 0,0,0,0,1,1);
        add(1,1,4'd6,0, 0,0,0,0,2,1);
        add(1,1,4'd7,0, 0,0,0,0,3,1);
        add(1,1,4'd8,0, 0,0,0,0,0,1);
        add(1,1,4'd5,0, 0,0,0,0,1,1);
        add(1,1,4'd6,0, 0,0,0,0,2,1);
        add(1,1,4'd7,0, 0,0,0,0,3,1);
        add(1,1,4'd9,0, 0,1,0,0,0,0);
        add(0,0,4'd0,0, 0,0,0,0,0,0);
        add(0,1,4'd1,0, 0,0,0,0,1,1);
        add(0,1,4'd2,0, 0,0,0,0,2,1);
        add(0,1,4'd3,0, 0,0,0,0,3,1);
        add(0,1,4'd4,0, 1,0,0,0,0,1);
        add(0,0,4'd0,1, 0,0,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].m, tbl[i].k, {4'h0, tbl[i].t}, tbl[i].c);
            chk_a($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ee, tbl[i].ec, tbl[i].eb,
                  tbl[i].ed, tbl[i].eo);
        end

        // ---------------- default password, open duration ----------------
        do_reset(1'b1, 1'b0, 1'b0);
        verify4_a(4'd0);
        chk("open_rise", a_aberto, 1);
        n = 1;
        for (int i = 0; i < 600; i++) begin
            idle_cyc();
            if (a_aberto) n++;
            else break;
        end
        chk("open_len", n, 500);
        chk("open_end.digitos", a_dig, 0);
        chk("open_end.ocupado", a_ocup, 0);

        // ---------------- lockout ----------------
        do_reset(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) begin
            verify4_a(4'd1);
            chk($sformatf("lk_try%0d.erro", e), a_erro, 1);
            chk($sformatf("lk_try%0d.bloq", e), a_bloq, (e == 2) ? 1 : 0);
        end
        n = 1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 8'h00, i[0]);
            if (a_bloq) begin
                n++;
                chk("lk_hold.aberto", a_aberto, 0);
            end else begin
                break;
            end
        end
        chk("lk_len", n, 16);
        chk("lk_end.ocupado", a_ocup, 0);
        verify4_a(4'd0);
        chk("lk_after.aberto", a_aberto, 1);

        // ---------------- cancel keeps the failure count ----------------
        do_reset(1'b1, 1'b0, 1'b0);
        verify4_a(4'd2);
        verify4_a(4'd2);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        chk("cx_pre.digitos", a_dig, 2);
        drive(1'b0, 1'b1, 8'h00, 1'b1);
        chk_a("cx", 0, 0, 0, 0, 0, 0);
        verify4_a(4'd2);
        chk("cx_third.erro", a_erro, 1);
        chk("cx_third.bloq", a_bloq, 1);

        // ---------------- inter-key timeout ----------------
        do_reset(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        repeat (19) idle_cyc();
        chk("to19.ocupado", a_ocup, 1);
        chk("to19.digitos", a_dig, 2);
        idle_cyc();
        chk_a("to20", 0, 0, 0, 0, 0, 0);
        verify4_a(4'd0);
        chk("to_after.aberto", a_aberto, 1);

        // ---------------- single-digit variant ----------------
        do_reset(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("c_a5.aberto", c_aberto, 1);
        chk("c_a5.digitos", c_dig, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("c_cx.aberto", c_aberto, 0);
        drive(1'b0, 1'b1, 8'hA4, 1'b0);
        chk("c_a4.erro", c_erro, 1);
        chk("c_a4.aberto", c_aberto, 0);
        drive(1'b1, 1'b1, 8'h3C, 1'b0);
        chk("c_seta.ocupado", c_ocup, 1);
        drive(1'b1, 1'b1, 8'h3C, 1'b0);
        chk("c_cfg.config_ok", c_cfg, 1);
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("c_old.erro", c_erro, 1);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("c_new.aberto", c_aberto, 1);
        idle_cyc();
        #3 rst_c = 1'b0;
        #1;
        chk("c_async.aberto", c_aberto, 0);
        chk("c_async.ocupado", c_ocup, 0);
        @(posedge clk);
        #1;
        rst_c = 1'b1;
        drive(1'b0, 1'b1, 8'hA5, 1'b0);
        chk("c_rst_pwd.aberto", c_aberto, 1);

        // ---------------- randomized run on DUT B ----------------
        do_reset(1'b0, 1'b1, 1'b0);
        m_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            kp = (((cyc / 150) % 4) == 3) ? 2 : 6;
            k  = ($urandom % 10) < kp;
            c  = ($urandom % 40) == 0;
            m  = ($urandom % 3) == 0;
            exp_d = $urandom % 4;
            if (m_st == M_VER && m_cur.size() < NB)       exp_d = m_stored[m_cur.size()];
            else if (m_st == M_SETB && m_cur.size() < NB) exp_d = m_first[m_cur.size()];
            else if (m_st == M_IDLE && !m)                exp_d = m_stored[0];
            t = (($urandom % 4) != 0) ? exp_d : int'($urandom % 4);
            drive(m, k, 8'(t), c);
            m_step(m, k, t, c);
            chk("rnd.aberto",    b_aberto, (m_st == M_OPEN) ? 1 : 0);
            chk("rnd.erro",      b_erro,   m_erro);
            chk("rnd.config_ok", b_cfg,    m_cfg);
            chk("rnd.bloqueado", b_bloq,   (m_st == M_LOCK) ? 1 : 0);
            chk("rnd.digitos",   b_dig,    m_cur.size());
            chk("rnd.ocupado",   b_ocup,   (m_st != M_IDLE) ? 1 : 0);
            if (failures > 40) break;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
